// File: rtl/tx_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tx_stream_bridge
// Purpose  : AHIR read pipe to AXI-stream MAC transmit bridge with a circular
//            buffer and optional store-and-forward frame gating.
// Revision : 1.0
// ============================================================================
module tx_stream_bridge #(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8,
    parameter int PIPE_W    = DATA_W + KEEP_W + 1,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int STORE_FWD = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PIPE_W-1:0]   read_pipe_data,
    output logic                read_pipe_req,
    input  logic                read_pipe_ack,
    output logic                tx_axis_resetn,
    output logic [DATA_W-1:0]   tx_axis_tdata,
    output logic [KEEP_W-1:0]   tx_axis_tkeep,
    output logic                tx_axis_tvalid,
    output logic                tx_axis_tlast,
    output logic                tx_axis_tuser,
    input  logic                tx_axis_tready,
    output logic [ADDR_W:0]     tx_fill,
    output logic [15:0]         tx_frame_count
);

    localparam logic [ADDR_W:0] c_full = (ADDR_W+1)'(DEPTH);

    logic [PIPE_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_fill;
    logic [ADDR_W:0]   r_cf_cnt;
    logic              r_mid_frame;
    logic              r_tvalid;
    logic              r_tlast;
    logic [DATA_W-1:0] r_tdata;
    logic [KEEP_W-1:0] r_tkeep;
    logic              r_resetn;
    logic [15:0]       r_frame_count;

    logic              w_req;
    logic              w_wr;
    logic              w_load;
    logic              w_start_ok;
    logic              w_wr_last;
    logic              w_pop_last;
    logic [PIPE_W-1:0] w_head;

    assign w_req      = !reset && (r_fill != c_full);
    assign w_wr       = w_req && read_pipe_ack;
    assign w_head     = r_mem[r_rd_ptr];
    // A full buffer must be allowed to start, or a frame longer than DEPTH
    // could never complete and the bridge would deadlock.
    assign w_start_ok = r_mid_frame || (STORE_FWD == 0) || (r_cf_cnt != '0) || (r_fill == c_full);
    assign w_load     = (!r_tvalid || tx_axis_tready) && (r_fill != '0) && w_start_ok;
    assign w_wr_last  = w_wr && read_pipe_data[PIPE_W-1];
    assign w_pop_last = w_load && w_head[PIPE_W-1];

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= read_pipe_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_fill      <= '0;
            r_cf_cnt    <= '0;
            r_mid_frame <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_load) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_mid_frame <= !w_head[PIPE_W-1];
            end
            case ({w_wr, w_load})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
            case ({w_wr_last, w_pop_last})
                2'b10:   r_cf_cnt <= r_cf_cnt + 1'b1;
                2'b01:   r_cf_cnt <= r_cf_cnt - 1'b1;
                default: r_cf_cnt <= r_cf_cnt;
            endcase
        end
    end

    // Output register holds while tvalid && !tready since w_load is then 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tvalid      <= 1'b0;
            r_tlast       <= 1'b0;
            r_tdata       <= '0;
            r_tkeep       <= '0;
            r_frame_count <= '0;
            r_resetn      <= 1'b0;
        end else begin
            r_resetn <= 1'b1;
            if (w_load) begin
                {r_tlast, r_tdata, r_tkeep} <= w_head;
                r_tvalid                    <= 1'b1;
            end else if (tx_axis_tready) begin
                r_tvalid <= 1'b0;
            end
            if (r_tvalid && tx_axis_tready && r_tlast) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign read_pipe_req  = w_req;
    assign tx_axis_resetn = r_resetn;
    assign tx_axis_tdata  = r_tdata;
    assign tx_axis_tkeep  = r_tkeep;
    assign tx_axis_tvalid = r_tvalid;
    assign tx_axis_tlast  = r_tlast;
    assign tx_axis_tuser  = 1'b0;
    assign tx_fill        = r_fill;
    assign tx_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_tx_stream_bridge.sv
`default_nettype none
// Testbench for tx_stream_bridge: a store-and-forward and a cut-through
// instance checked against a queue-based word/frame model.
module tb_tx_stream_bridge;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int PIPE_W = DATA_W + KEEP_W + 1;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    typedef logic [PIPE_W-1:0] word_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    word_t             sf_data = '0, ct_data = '0;
    logic              sf_ack = 1'b0, ct_ack = 1'b0;
    logic              sf_tready = 1'b0, ct_tready = 1'b0;
    logic              sf_req, ct_req, sf_resetn, ct_resetn;
    logic [DATA_W-1:0] sf_tdata, ct_tdata;
    logic [KEEP_W-1:0] sf_tkeep, ct_tkeep;
    logic              sf_tvalid, ct_tvalid, sf_tlast, ct_tlast, sf_tuser, ct_tuser;
    logic [ADDR_W:0]   sf_fill, ct_fill;
    logic [15:0]       sf_fc, ct_fc;

    tx_stream_bridge #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .PIPE_W(PIPE_W),
                       .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STORE_FWD(1)) u_sf (
        .clk(clk), .reset(reset),
        .read_pipe_data(sf_data), .read_pipe_req(sf_req), .read_pipe_ack(sf_ack),
        .tx_axis_resetn(sf_resetn), .tx_axis_tdata(sf_tdata), .tx_axis_tkeep(sf_tkeep),
        .tx_axis_tvalid(sf_tvalid), .tx_axis_tlast(sf_tlast), .tx_axis_tuser(sf_tuser),
        .tx_axis_tready(sf_tready), .tx_fill(sf_fill), .tx_frame_count(sf_fc)
    );

    tx_stream_bridge #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .PIPE_W(PIPE_W),
                       .DEPTH(DEPTH), .ADDR_W(ADDR_W), .STORE_FWD(0)) u_ct (
        .clk(clk), .reset(reset),
        .read_pipe_data(ct_data), .read_pipe_req(ct_req), .read_pipe_ack(ct_ack),
        .tx_axis_resetn(ct_resetn), .tx_axis_tdata(ct_tdata), .tx_axis_tkeep(ct_tkeep),
        .tx_axis_tvalid(ct_tvalid), .tx_axis_tlast(ct_tlast), .tx_axis_tuser(ct_tuser),
        .tx_axis_tready(ct_tready), .tx_fill(ct_fill), .tx_frame_count(ct_fc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: words waiting to be offered, words accepted by the bridge, beats seen at AXI.
    word_t sf_pend[$], sf_exp[$], sf_obs[$];
    word_t ct_pend[$], ct_exp[$], ct_obs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input int sf_pct, input int ct_pct);
        bit    sf_acc, ct_acc, sf_beat, ct_beat;
        word_t sf_w, ct_w;
        sf_ack  = (sf_pend.size() > 0) && (int'($urandom_range(99)) < sf_pct);
        sf_data = (sf_pend.size() > 0) ? sf_pend[0] : '0;
        ct_ack  = (ct_pend.size() > 0) && (int'($urandom_range(99)) < ct_pct);
        ct_data = (ct_pend.size() > 0) ? ct_pend[0] : '0;
        sf_acc  = sf_req && sf_ack;
        ct_acc  = ct_req && ct_ack;
        sf_beat = sf_tvalid && sf_tready;
        ct_beat = ct_tvalid && ct_tready;
        sf_w    = {sf_tlast, sf_tdata, sf_tkeep};
        ct_w    = {ct_tlast, ct_tdata, ct_tkeep};
        tick();
        if (sf_acc)  sf_exp.push_back(sf_pend.pop_front());
        if (ct_acc)  ct_exp.push_back(ct_pend.pop_front());
        if (sf_beat) sf_obs.push_back(sf_w);
        if (ct_beat) ct_obs.push_back(ct_w);
    endtask

    task automatic push_frame(input int len, input bit to_sf, input bit to_ct);
        for (int i = 0; i < len; i++) begin
            word_t w;
            w = {(i == len - 1), $urandom, $urandom, KEEP_W'($urandom)};
            if (to_sf) sf_pend.push_back(w);
            if (to_ct) ct_pend.push_back(w);
        end
    endtask

    task automatic clear_model();
        sf_pend.delete(); sf_exp.delete(); sf_obs.delete();
        ct_pend.delete(); ct_exp.delete(); ct_obs.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; sf_tready = 1'b1; ct_tready = 1'b1;
        repeat (3) cyc(0, 0);
        n_tests++; if (sf_resetn !== 1'b0 || ct_resetn !== 1'b0) begin n_fail++; $display("FAIL reset_resetn_low: got %b/%b want 0/0", sf_resetn, ct_resetn); end
        n_tests++; if (sf_req !== 1'b0 || ct_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b/%b want 0/0", sf_req, ct_req); end
        n_tests++; if (sf_tvalid !== 1'b0 || sf_tlast !== 1'b0 || sf_tuser !== 1'b0) begin n_fail++; $display("FAIL reset_ctrl: got v%b l%b u%b want 000", sf_tvalid, sf_tlast, sf_tuser); end
        n_tests++; if (sf_tdata !== '0 || sf_tkeep !== '0) begin n_fail++; $display("FAIL reset_data: got %h/%h want 0/0", sf_tdata, sf_tkeep); end
        n_tests++; if (sf_fill !== '0 || sf_fc !== '0 || ct_fc !== '0) begin n_fail++; $display("FAIL reset_counts: got fill %0d fc %0d/%0d want 0", sf_fill, sf_fc, ct_fc); end
        reset = 1'b0;
        cyc(0, 0);
        n_tests++; if (sf_resetn !== 1'b1 || ct_resetn !== 1'b1) begin n_fail++; $display("FAIL reset_resetn_high: got %b/%b want 1/1", sf_resetn, ct_resetn); end
        n_tests++; if (sf_req !== 1'b1 || ct_req !== 1'b1) begin n_fail++; $display("FAIL reset_req_release: got %b/%b want 1/1", sf_req, ct_req); end
        n_tests++; if (sf_tvalid !== 1'b0 || ct_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid_release: got %b/%b want 0/0", sf_tvalid, ct_tvalid); end
    endtask

    task automatic test_cut_through();
        word_t       w;
        logic [15:0] fc0;
        w = {1'b1, 64'h1122334455667788, 8'hFF};
        fc0 = ct_fc; ct_tready = 1'b1;
        ct_pend.push_back(w);
        cyc(0, 100);
        n_tests++; if (ct_tvalid !== 1'b0 || ct_fill !== 5'd1) begin n_fail++; $display("FAIL ct_after_write: got v%b fill %0d want v0 fill 1", ct_tvalid, ct_fill); end
        cyc(0, 0);
        n_tests++; if (ct_tvalid !== 1'b1) begin n_fail++; $display("FAIL ct_latency: got tvalid %b want 1", ct_tvalid); end
        n_tests++; if ({ct_tlast, ct_tdata, ct_tkeep} !== w) begin n_fail++; $display("FAIL ct_fields: got %h want %h", {ct_tlast, ct_tdata, ct_tkeep}, w); end
        cyc(0, 0);
        n_tests++; if (ct_fc !== fc0 + 16'd1 || ct_tvalid !== 1'b0) begin n_fail++; $display("FAIL ct_frame_count: got fc %0d v%b want %0d v0", ct_fc, ct_tvalid, fc0 + 16'd1); end
        clear_model();
    endtask

    task automatic test_store_fwd();
        word_t       f [4];
        logic [15:0] fc0;
        fc0 = sf_fc; sf_tready = 1'b1;
        push_frame(4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) f[i] = sf_pend[i];
        for (int i = 0; i < 4; i++) begin
            cyc(100, 0);
            n_tests++; if (sf_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_gate_w%0d: got tvalid %b want 0", i, sf_tvalid); end
            if (i < 3) begin
                repeat (2) begin
                    cyc(0, 0);
                    n_tests++; if (sf_tvalid !== 1'b0) begin n_fail++; $display("FAIL sf_gate_idle%0d: got tvalid %b want 0", i, sf_tvalid); end
                end
            end
        end
        cyc(0, 0);
        for (int j = 0; j < 4; j++) begin
            n_tests++; if (sf_tvalid !== 1'b1 || {sf_tlast, sf_tdata, sf_tkeep} !== f[j]) begin n_fail++; $display("FAIL sf_beat%0d: got v%b %h want v1 %h", j, sf_tvalid, {sf_tlast, sf_tdata, sf_tkeep}, f[j]); end
            cyc(0, 0);
        end
        n_tests++; if (sf_tvalid !== 1'b0 || sf_fc !== fc0 + 16'd1) begin n_fail++; $display("FAIL sf_frame_done: got v%b fc %0d want v0 fc %0d", sf_tvalid, sf_fc, fc0 + 16'd1); end
        clear_model();
    endtask

    task automatic test_backpressure();
        logic [15:0] fc0;
        word_t       cap;
        bit          held;
        int          cnt;
        fc0 = sf_fc; sf_tready = 1'b0; held = 1'b0; cnt = 0;
        push_frame(6, 1'b1, 1'b0);
        push_frame(30, 1'b1, 1'b0);
        while (sf_fill !== 5'd16 && cnt < 60) begin
            cyc(100, 0); cnt++;
            if (sf_tvalid === 1'b1) begin
                if (!held) begin
                    cap = {sf_tlast, sf_tdata, sf_tkeep}; held = 1'b1;
                end else begin
                    n_tests++; if ({sf_tlast, sf_tdata, sf_tkeep} !== cap) begin n_fail++; $display("FAIL bp_hold_fill: got %h want %h", {sf_tlast, sf_tdata, sf_tkeep}, cap); end
                end
            end
        end
        n_tests++; if (sf_fill !== 5'd16 || sf_req !== 1'b0 || !held) begin n_fail++; $display("FAIL bp_full: got fill %0d req %b held %b want 16 0 1", sf_fill, sf_req, held); end
        cyc(100, 0);
        n_tests++; if (sf_fill !== 5'd16 || sf_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_hold: got fill %0d req %b want 16 0", sf_fill, sf_req); end
        sf_tready = 1'b1;
        cyc(100, 0);
        n_tests++; if (sf_req !== 1'b1 || sf_fill !== 5'd15) begin n_fail++; $display("FAIL bp_req_after_pop: got req %b fill %0d want 1 15", sf_req, sf_fill); end
        repeat (8) cyc(100, 0);
        sf_tready = 1'b0;
        cap = {sf_tlast, sf_tdata, sf_tkeep};
        n_tests++; if (sf_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_midframe_valid: got tvalid %b want 1", sf_tvalid); end
        repeat (5) begin
            cyc(100, 0);
            n_tests++; if (sf_tvalid !== 1'b1 || {sf_tlast, sf_tdata, sf_tkeep} !== cap) begin n_fail++; $display("FAIL bp_stall_stable: got v%b %h want v1 %h", sf_tvalid, {sf_tlast, sf_tdata, sf_tkeep}, cap); end
        end
        sf_tready = 1'b1; cnt = 0;
        while ((sf_pend.size() > 0 || sf_obs.size() != sf_exp.size()) && cnt < 200) begin cyc(100, 0); cnt++; end
        n_tests++; if (sf_obs.size() != 36 || sf_exp.size() != 36) begin n_fail++; $display("FAIL bp_word_count: got %0d of %0d want 36", sf_obs.size(), sf_exp.size()); end
        for (int i = 0; i < sf_obs.size() && i < sf_exp.size(); i++) begin
            n_tests++; if (sf_obs[i] !== sf_exp[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, sf_obs[i], sf_exp[i]); end
        end
        n_tests++; if (sf_fc !== fc0 + 16'd2) begin n_fail++; $display("FAIL bp_frame_count: got %0d want %0d", sf_fc, fc0 + 16'd2); end
        clear_model();
    endtask

    task automatic test_oversize();
        logic [15:0] fc0;
        logic [4:0]  prev;
        int          cnt;
        fc0 = sf_fc; sf_tready = 1'b1; cnt = 0; prev = '0;
        push_frame(20, 1'b1, 1'b0);
        while (sf_tvalid !== 1'b1 && cnt < 60) begin prev = sf_fill; cyc(100, 0); cnt++; end
        n_tests++; if (sf_tvalid !== 1'b1 || prev !== 5'd16) begin n_fail++; $display("FAIL os_start_full: got v%b fill_before %0d want v1 16", sf_tvalid, prev); end
        cnt = 0;
        while ((sf_pend.size() > 0 || sf_obs.size() != sf_exp.size()) && cnt < 200) begin cyc(100, 0); cnt++; end
        n_tests++; if (sf_obs.size() != 20) begin n_fail++; $display("FAIL os_word_count: got %0d want 20", sf_obs.size()); end
        for (int i = 0; i < sf_obs.size() && i < sf_exp.size(); i++) begin
            n_tests++; if (sf_obs[i] !== sf_exp[i]) begin n_fail++; $display("FAIL os_order[%0d]: got %h want %h", i, sf_obs[i], sf_exp[i]); end
        end
        n_tests++; if (sf_fc !== fc0 + 16'd1) begin n_fail++; $display("FAIL os_frame_count: got %0d want %0d", sf_fc, fc0 + 16'd1); end
        clear_model();
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        sf_tready = 1'b1; cnt = 0;
        push_frame(6, 1'b1, 1'b0);
        while (sf_obs.size() < 2 && cnt < 60) begin cyc(100, 0); cnt++; end
        n_tests++; if (sf_obs.size() != 2 || sf_obs[0][PIPE_W-1] !== 1'b0 || sf_obs[1][PIPE_W-1] !== 1'b0) begin n_fail++; $display("FAIL rst_partial_beats: got %0d beats want 2 without tlast", sf_obs.size()); end
        sf_ack = 1'b0; ct_ack = 1'b0; reset = 1'b1;
        tick();
        n_tests++; if (sf_tvalid !== 1'b0 || sf_fill !== '0 || sf_resetn !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clear: got v%b fill %0d resetn %b want 0 0 0", sf_tvalid, sf_fill, sf_resetn); end
        reset = 1'b0;
        clear_model();
        cyc(0, 0);
        push_frame(1, 1'b1, 1'b0);
        cnt = 0;
        while ((sf_pend.size() > 0 || sf_obs.size() != sf_exp.size()) && cnt < 60) begin cyc(100, 0); cnt++; end
        n_tests++; if (sf_obs.size() != 1 || sf_exp.size() != 1 || sf_obs[0] !== sf_exp[0]) begin n_fail++; $display("FAIL rst_next_frame: got %0d beats want 1 matching", sf_obs.size()); end
        n_tests++; if (sf_fc !== 16'd1) begin n_fail++; $display("FAIL rst_frame_count: got %0d want 1", sf_fc); end
        clear_model();
    endtask

    task automatic test_random();
        logic [15:0] sf0, ct0;
        int          cnt;
        sf0 = sf_fc; ct0 = ct_fc;
        clear_model();
        for (int f = 0; f < 20; f++) push_frame(int'($urandom_range(1, 8)), 1'b1, 1'b1);
        for (int c = 0; c < 400; c++) begin
            sf_tready = ($urandom_range(3) != 0);
            ct_tready = ($urandom_range(3) != 0);
            cyc(70, 70);
            n_tests++; if (int'(sf_fill) != sf_exp.size() - sf_obs.size() - int'(sf_tvalid)) begin n_fail++; $display("FAIL rnd_fill: got %0d want %0d", sf_fill, sf_exp.size() - sf_obs.size() - int'(sf_tvalid)); end
        end
        sf_tready = 1'b1; ct_tready = 1'b1; cnt = 0;
        while ((sf_pend.size() > 0 || ct_pend.size() > 0 || sf_obs.size() != sf_exp.size() || ct_obs.size() != ct_exp.size()) && cnt < 500) begin
            cyc(100, 100); cnt++;
        end
        n_tests++; if (sf_pend.size() != 0 || ct_pend.size() != 0 || sf_obs.size() != sf_exp.size() || ct_obs.size() != ct_exp.size()) begin n_fail++; $display("FAIL rnd_drain: got sf %0d/%0d ct %0d/%0d delivered", sf_obs.size(), sf_exp.size(), ct_obs.size(), ct_exp.size()); end
        for (int i = 0; i < sf_obs.size() && i < sf_exp.size(); i++) begin
            n_tests++; if (sf_obs[i] !== sf_exp[i]) begin n_fail++; $display("FAIL rnd_sf_order[%0d]: got %h want %h", i, sf_obs[i], sf_exp[i]); end
        end
        for (int i = 0; i < ct_obs.size() && i < ct_exp.size(); i++) begin
            n_tests++; if (ct_obs[i] !== ct_exp[i]) begin n_fail++; $display("FAIL rnd_ct_order[%0d]: got %h want %h", i, ct_obs[i], ct_exp[i]); end
        end
        n_tests++; if (sf_fc !== sf0 + 16'd20 || ct_fc !== ct0 + 16'd20) begin n_fail++; $display("FAIL rnd_frame_count: got %0d/%0d want %0d/%0d", sf_fc, ct_fc, sf0 + 16'd20, ct0 + 16'd20); end
        clear_model();
    endtask

    initial begin
        test_reset();
        test_cut_through();
        test_store_fwd();
        test_backpressure();
        test_oversize();
        test_reset_mid_frame();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
